// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: sequences one M-extension op from the CPU into the divider or multiplier and returns its result
module mdu_issue_ctrl #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [RD_W-1:0] req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            resp_exception,
  input  logic            flush,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_in_valid,
  output logic [1:0]      div_type,
  output logic            div_cpu_busy,
  input  logic [XLEN-1:0] div_out,
  input  logic            div_out_valid,
  input  logic            div_busy,
  input  logic            div_exception,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic            mul_in_valid,
  output logic [1:0]      mul_type,
  output logic            mul_cpu_busy,
  input  logic [XLEN-1:0] mul_out,
  input  logic            mul_out_valid,
  input  logic            mul_busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  state_t          r_state;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_rs1, r_rs2, r_data;
  logic [RD_W-1:0] r_rd;
  logic            r_exc;
  logic            w_div, w_busy, w_out_valid, w_start, w_release;
  logic [XLEN-1:0] w_out;
  assign w_div          = r_funct3[2];
  assign w_busy         = w_div ? div_busy : mul_busy;
  assign w_out_valid    = w_div ? div_out_valid : mul_out_valid;
  assign w_out          = w_div ? div_out : mul_out;
  assign w_start        = (r_state == ISSUE) && !w_busy;
  assign w_release      = (r_state == WAIT) || (r_state == DRAIN);
  assign req_ready      = (r_state == IDLE);
  assign resp_valid     = (r_state == RESP);
  assign resp_data      = r_data;
  assign resp_rd        = r_rd;
  assign resp_exception = r_exc;
  assign div_dividend   = r_rs1;
  assign div_divisor    = r_rs2;
  assign div_type       = r_funct3[1:0];
  assign div_in_valid   = w_start && w_div;
  assign div_cpu_busy   = !(w_release && w_div);
  assign mul_a          = r_rs1;
  assign mul_b          = r_rs2;
  assign mul_type       = r_funct3[1:0];
  assign mul_in_valid   = w_start && !w_div;
  assign mul_cpu_busy   = !(w_release && !w_div);
  // op sequencing: accept, issue once the unit is idle, collect, hand back; flush abandons and drains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_funct3 <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_data   <= '0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid && !flush) begin
          r_funct3 <= req_funct3;
          r_rs1    <= req_rs1;
          r_rs2    <= req_rs2;
          r_rd     <= req_rd;
          r_state  <= ISSUE;
        end
        ISSUE: r_state <= flush ? (w_start ? DRAIN : IDLE) : (w_start ? WAIT : ISSUE);
        WAIT: if (w_out_valid) begin
          r_data  <= w_out;
          r_exc   <= w_div && div_exception;
          r_state <= flush ? IDLE : RESP;
        end else if (flush) r_state <= DRAIN;
        RESP:    if (flush || resp_ready) r_state <= IDLE;
        DRAIN:   if (w_out_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: directed vector and corner-sequence checks of the MDU issue controller against behavioural units
module tb_mdu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_exception, flush;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2, resp_data, div_dividend, div_divisor, div_out, mul_a, mul_b, mul_out;
  logic [4:0]  req_rd, resp_rd;
  logic        div_in_valid, div_cpu_busy, div_out_valid, div_busy, div_exception;
  logic        mul_in_valid, mul_cpu_busy, mul_out_valid, mul_busy;
  logic [1:0]  div_type, mul_type;
  int          checks = 0, failures = 0, lat, d_cnt, m_cnt;
  logic [31:0] d_res, m_res;
  logic        d_exc;
  always #5 clk = ~clk;

  mdu_issue_ctrl #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_exception(resp_exception), .flush(flush),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_in_valid(div_in_valid), .div_type(div_type),
    .div_cpu_busy(div_cpu_busy), .div_out(div_out), .div_out_valid(div_out_valid), .div_busy(div_busy),
    .div_exception(div_exception), .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid),
    .mul_type(mul_type), .mul_cpu_busy(mul_cpu_busy), .mul_out(mul_out), .mul_out_valid(mul_out_valid),
    .mul_busy(mul_busy)
  );

  function automatic logic [32:0] div_ref(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {1'b1, t[1] ? a : 32'hFFFFFFFF};
    if (!t[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, t[1] ? 32'h0 : 32'h80000000};
    case (t)
      2'b00:   return {1'b0, 32'($signed(a) / $signed(b))};
      2'b01:   return {1'b0, a / b};
      2'b10:   return {1'b0, 32'($signed(a) % $signed(b))};
      default: return {1'b0, a % b};
    endcase
  endfunction

  function automatic logic [31:0] mul_ref(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    p = (t == 2'b01) ? sa * sb : (t == 2'b10) ? sa * ub : ua * ub;
    return (t == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // behavioural divider: 36 cycles normally, 2 on exception, holds DONE while cpu_busy
  always @(posedge clk) begin
    if (rst) d_cnt <= 0;
    else if (d_cnt == 0 && div_in_valid) begin
      {d_exc, d_res} <= div_ref(div_type, div_dividend, div_divisor);
      d_cnt <= div_ref(div_type, div_dividend, div_divisor) >> 32 != 0 ? 2 : 36;
    end else if (d_cnt > 1) d_cnt <= d_cnt - 1;
    else if (d_cnt == 1 && !div_cpu_busy) d_cnt <= 0;
  end
  assign div_out_valid = (d_cnt == 1);
  assign div_busy      = (d_cnt != 0);
  assign div_out       = d_res;
  assign div_exception = d_exc;

  // behavioural multiplier: 3 cycles, holds DONE while cpu_busy
  always @(posedge clk) begin
    if (rst) m_cnt <= 0;
    else if (m_cnt == 0 && mul_in_valid) begin
      m_res <= mul_ref(mul_type, mul_a, mul_b);
      m_cnt <= 3;
    end else if (m_cnt > 1) m_cnt <= m_cnt - 1;
    else if (m_cnt == 1 && !mul_cpu_busy) m_cnt <= 0;
  end
  assign mul_out_valid = (m_cnt == 1);
  assign mul_busy      = (m_cnt != 0);
  assign mul_out       = m_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // presents one request; returns at the negedge of the cycle after acceptance (T+1)
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    chk("req_ready_before_op", req_ready, 1);
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start_op(f3, a, b, rd);
    lat = 0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      if (n == 1) begin
        chk("issue_strobe", f3[2] ? div_in_valid : mul_in_valid, 1);
        chk("unit_type", f3[2] ? div_type : mul_type, {30'h0, f3[1:0]});
        chk("unit_op_a", f3[2] ? div_dividend : mul_a, a);
        chk("unit_op_b", f3[2] ? div_divisor : mul_b, b);
      end
      if (resp_valid) lat = n;
      else @(negedge clk);
    end
    chk("resp_timeout", lat != 0, 1);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    int          lat;
  } vec_t;
  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0, 38};
    vecs[1]  = '{3'b111, 32'd100, 32'd7, 5'd6, 32'd2, 1'b0, 38};
    vecs[2]  = '{3'b100, 32'hFFFFFF9C, 32'd7, 5'd7, 32'hFFFFFFF2, 1'b0, 38};
    vecs[3]  = '{3'b110, 32'hFFFFFF9C, 32'd7, 5'd8, 32'hFFFFFFFE, 1'b0, 38};
    vecs[4]  = '{3'b110, 32'h12345678, 32'd0, 5'd9, 32'h12345678, 1'b1, 4};
    vecs[5]  = '{3'b100, 32'h12345678, 32'd0, 5'd10, 32'hFFFFFFFF, 1'b1, 4};
    vecs[6]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b1, 4};
    vecs[7]  = '{3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0, 5};
    vecs[8]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE, 1'b0, 5};
    vecs[9]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd13, 32'h40000000, 1'b0, 5};
    vecs[10] = '{3'b010, 32'hFFFFFFFF, 32'd2, 5'd14, 32'hFFFFFFFF, 1'b0, 5};
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
    req_funct3 = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_div_in_valid", div_in_valid, 0);
    chk("reset_mul_in_valid", mul_in_valid, 0);
    chk("reset_resp_exception", resp_exception, 0);
    chk("reset_resp_data", resp_data, 0);
    // vector table
    resp_ready = 1'b1;
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_data", i), resp_data, vecs[i].data);
      chk($sformatf("v%0d_rd", i), {27'h0, resp_rd}, {27'h0, vecs[i].rd});
      chk($sformatf("v%0d_exc", i), resp_exception, vecs[i].exc);
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), req_ready, 1);
      chk($sformatf("v%0d_resp_dropped", i), resp_valid, 0);
    end
    // backpressure on the response channel
    resp_ready = 1'b0;
    run_op(3'b101, 32'd1000, 32'd10, 5'd3);
    chk("bp_latency", 32'(lat), 38);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_data", resp_data, 100);
      chk("bp_rd", {27'h0, resp_rd}, 3);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_div_busy", div_busy, 0);
      chk("bp_div_cpu_busy", div_cpu_busy, 1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", req_ready, 1);
    chk("bp_release_resp", resp_valid, 0);
    // flush while the divider is working: drain, no response
    start_op(3'b101, 32'd100, 32'd7, 5'd4);
    begin
      int ready_at = 0, seen = 0;
      for (int n = 1; n <= 80 && ready_at == 0; n++) begin
        flush = (n == 10);
        if (resp_valid) seen++;
        if (n == 20) begin
          chk("drain_req_ready", req_ready, 0);
          chk("drain_div_cpu_busy", div_cpu_busy, 0);
        end
        if (req_ready) ready_at = n;
        else @(negedge clk);
      end
      flush = 1'b0;
      chk("flush_no_resp", 32'(seen), 0);
      chk("flush_idle_cycle", 32'(ready_at), 38);
    end
    run_op(3'b101, 32'd9, 32'd3, 5'd2);
    chk("post_flush_data", resp_data, 3);
    @(negedge clk);
    // flush during RESP wins over resp_ready
    resp_ready = 1'b0;
    run_op(3'b000, 32'd3, 32'd5, 5'd1);
    chk("resp_flush_data", resp_data, 15);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("resp_flush_resp_valid", resp_valid, 0);
    chk("resp_flush_idle", req_ready, 1);
    // request with flush in IDLE is ignored
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'b101; req_rs1 = 32'd8; req_rs2 = 32'd2;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_req_ready", req_ready, 1);
    chk("idle_flush_no_issue", div_in_valid | mul_in_valid, 0);
    // reset mid-op
    start_op(3'b101, 32'd100, 32'd7, 5'd6);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    run_op(3'b101, 32'd50, 32'd5, 5'd7);
    chk("post_rst_latency", 32'(lat), 38);
    chk("post_rst_data", resp_data, 10);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
